// File: rtl/rat_io_responder.sv
// rtl/rat_io_responder.sv - CPU port-bus peripheral endpoint: LED/SSEG regs, TX/RX FIFOs,
// synchronized switches/buttons and a masked level interrupt.
module rat_io_responder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic [7:0] sw,
    input  logic [3:0] btn,
    output logic [7:0] leds,
    output logic [7:0] sseg,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0] r_sw_sync  [SYNC_STAGES];
    logic [3:0] r_btn_sync [SYNC_STAGES];
    logic [3:0] r_btn_prev;
    logic [7:0] r_leds, r_sseg;
    logic [3:0] r_int_pend;
    logic [4:0] r_int_mask;
    logic       r_tx_ovf, r_rx_ovf, r_int;
    logic [7:0] r_tx_mem [FIFO_DEPTH];
    logic [7:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;

    logic [7:0] w_sw_s;
    logic [3:0] w_btn_s, w_btn_rise;
    logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic       w_tx_push, w_tx_pop, w_tx_wr, w_rx_push, w_rx_pop;
    logic [4:0] w_pend_all;

    assign w_sw_s     = r_sw_sync[SYNC_STAGES-1];
    assign w_btn_s    = r_btn_sync[SYNC_STAGES-1];
    assign w_btn_rise = w_btn_s & ~r_btn_prev;

    // Full when pointers address the same slot but sit on different laps.
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) && (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) && (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);

    assign w_tx_push = io_strb && (port_id == 8'h80);
    assign w_tx_pop  = !w_tx_empty && tx_ready;
    assign w_tx_wr   = w_tx_push && (!w_tx_full || w_tx_pop);
    assign w_rx_push = rx_valid && !w_rx_full;
    assign w_rx_pop  = io_strb && (port_id == 8'h82) && !w_rx_empty;

    assign w_pend_all = {!w_rx_empty, r_int_pend};

    assign leds      = r_leds;
    assign sseg      = r_sseg;
    assign tx_data   = r_tx_mem[r_tx_rptr[AW-1:0]];
    assign tx_valid  = !w_tx_empty;
    assign rx_ready  = !w_rx_full;
    assign interrupt = r_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= 8'h00;
                r_btn_sync[i] <= 4'h0;
            end
            r_btn_prev <= 4'h0;
        end else begin
            r_sw_sync[0]  <= sw;
            r_btn_sync[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= r_sw_sync[i-1];
                r_btn_sync[i] <= r_btn_sync[i-1];
            end
            r_btn_prev <= w_btn_s;
        end
    end

    // W1C is applied first so a coincident set on the same bit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds     <= 8'h00;
            r_sseg     <= 8'h00;
            r_int_mask <= 5'h00;
            r_int_pend <= 4'h0;
            r_tx_ovf   <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            if (io_strb && port_id == 8'h40) r_leds <= out_port;
            if (io_strb && port_id == 8'h41) r_sseg <= out_port;
            if (io_strb && port_id == 8'hF1) r_int_mask <= out_port[4:0];
            r_int_pend <= (r_int_pend & ~((io_strb && port_id == 8'hF0) ? out_port[3:0] : 4'h0))
                          | w_btn_rise;
            r_tx_ovf <= (r_tx_ovf && !(io_strb && port_id == 8'h81 && out_port[4]))
                        || (w_tx_push && w_tx_full && !w_tx_pop);
            r_rx_ovf <= (r_rx_ovf && !(io_strb && port_id == 8'h81 && out_port[5]))
                        || (rx_valid && w_rx_full);
            r_int <= |(w_pend_all & r_int_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_tx_wr) begin
                r_tx_mem[r_tx_wptr[AW-1:0]] <= out_port;
                r_tx_wptr <= r_tx_wptr + PTR_ONE;
            end
            if (w_tx_pop) r_tx_rptr <= r_tx_rptr + PTR_ONE;
            if (w_rx_push) begin
                r_rx_mem[r_rx_wptr[AW-1:0]] <= rx_data;
                r_rx_wptr <= r_rx_wptr + PTR_ONE;
            end
            if (w_rx_pop) r_rx_rptr <= r_rx_rptr + PTR_ONE;
        end
    end

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            8'h20: in_port = w_sw_s;
            8'h21: in_port = {4'b0, w_btn_s};
            8'h80: in_port = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[AW-1:0]];
            8'h81: in_port = {2'b0, r_rx_ovf, r_tx_ovf, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
            8'hF0: in_port = {3'b0, w_pend_all};
            8'hF1: in_port = {3'b0, r_int_mask};
            default: in_port = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_rat_io_responder.sv
// tb/tb_rat_io_responder.sv - directed self-checking bench for rat_io_responder.
module tb_rat_io_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_id, out_port, in_port, sw, leds, sseg, tx_data, rx_data;
    logic [3:0] btn;
    logic       io_strb, interrupt, tx_valid, tx_ready, rx_valid, rx_ready;
    int         n_checks = 0;
    int         n_fails  = 0;

    rat_io_responder #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port), .io_strb(io_strb),
        .in_port(in_port), .interrupt(interrupt), .sw(sw), .btn(btn), .leds(leds), .sseg(sseg),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic io_wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; io_strb = 1'b1;
        @(negedge clk);
        io_strb = 1'b0; port_id = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
        port_id = p;
        #1;
        chk(tag, in_port, exp);
        port_id = 8'h00;
    endtask

    task automatic rx_send(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
        sw = 8'h00; btn = 4'h0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        chk("rst_leds", leds, 8'h00);
        chk("rst_sseg", sseg, 8'h00);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        chk("rst_interrupt", {7'b0, interrupt}, 8'h00);
        rd("rst_status", 8'h81, 8'h05);
        rd("rst_pend", 8'hF0, 8'h00);

        io_wr(8'h40, 8'hA5);
        chk("leds_wr", leds, 8'hA5);
        rd("rd_unmapped_40", 8'h40, 8'h00);
        rd("rd_unmapped_99", 8'h99, 8'h00);
        io_wr(8'h41, 8'h3C);
        chk("sseg_wr", sseg, 8'h3C);
        io_wr(8'h99, 8'hFF);
        chk("unmapped_wr_leds", leds, 8'hA5);

        sw = 8'h5A;
        cyc(1);
        rd("sw_not_yet", 8'h20, 8'h00);
        cyc(1);
        rd("sw_sync", 8'h20, 8'h5A);

        for (int k = 1; k <= 9; k++) io_wr(8'h80, 8'(k));
        chk("tx_valid_full", {7'b0, tx_valid}, 8'h01);
        chk("tx_head", tx_data, 8'h01);
        rd("tx_full_ovf_status", 8'h81, 8'h19);
        io_wr(8'h81, 8'h10);
        rd("tx_ovf_w1c", 8'h81, 8'h09);
        tx_ready = 1'b1;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("tx_out_%0d", k), tx_data, 8'(k));
            @(negedge clk);
            #1;
        end
        tx_ready = 1'b0;
        chk("tx_drained", {7'b0, tx_valid}, 8'h00);
        rd("tx_empty_status", 8'h81, 8'h05);

        for (int k = 0; k < 8; k++) rx_send(8'h11 + 8'(k));
        chk("rx_ready_full", {7'b0, rx_ready}, 8'h00);
        rd("rx_full_status", 8'h81, 8'h06);
        rx_send(8'h99);
        rd("rx_ovf_status", 8'h81, 8'h26);
        rd("rx_head0", 8'h80, 8'h11);
        io_wr(8'h82, 8'h00);
        rd("rx_head1", 8'h80, 8'h12);
        chk("rx_ready_after_pop", {7'b0, rx_ready}, 8'h01);
        for (int k = 0; k < 7; k++) io_wr(8'h82, 8'h00);
        rd("rx_empty_head", 8'h80, 8'h00);
        io_wr(8'h82, 8'h00);
        io_wr(8'h81, 8'h20);
        rd("rx_ovf_w1c", 8'h81, 8'h05);

        io_wr(8'hF1, 8'h01);
        rd("mask_rd", 8'hF1, 8'h01);
        btn = 4'h1;
        cyc(2);
        rd("pend_before", 8'hF0, 8'h00);
        cyc(1);
        rd("pend_set", 8'hF0, 8'h01);
        chk("int_not_yet", {7'b0, interrupt}, 8'h00);
        cyc(1);
        chk("int_set", {7'b0, interrupt}, 8'h01);
        rd("btn_rd", 8'h21, 8'h01);
        io_wr(8'hF0, 8'h01);
        rd("pend_w1c", 8'hF0, 8'h00);
        cyc(1);
        chk("int_clear", {7'b0, interrupt}, 8'h00);

        btn = 4'h3;
        cyc(3);
        rd("pend_bit1", 8'hF0, 8'h02);
        btn = 4'h1;
        cyc(3);
        btn = 4'h3;
        cyc(2);
        io_wr(8'hF0, 8'h02);
        rd("set_wins_w1c", 8'hF0, 8'h02);
        io_wr(8'hF0, 8'h02);
        rd("pend_bit1_clear", 8'hF0, 8'h00);
        chk("int_masked_off", {7'b0, interrupt}, 8'h00);

        io_wr(8'hF1, 8'h10);
        rx_send(8'h77);
        rd("pend_rx_level", 8'hF0, 8'h10);
        cyc(1);
        chk("int_rx", {7'b0, interrupt}, 8'h01);
        io_wr(8'hF0, 8'h10);
        rd("pend_rx_not_w1c", 8'hF0, 8'h10);
        io_wr(8'h82, 8'h00);
        rd("pend_rx_drained", 8'hF0, 8'h00);
        cyc(1);
        chk("int_rx_clear", {7'b0, interrupt}, 8'h00);

        rx_send(8'hAA);
        rx_send(8'hBB);
        io_wr(8'h80, 8'hCC);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst2_leds", leds, 8'h00);
        chk("rst2_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst2_rx_ready", {7'b0, rx_ready}, 8'h01);
        rd("rst2_status", 8'h81, 8'h05);
        rd("rst2_mask", 8'hF1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
